// File: rtl/vrot_pkg.sv
// Shared types and helpers for the vector rotate/shift pipeline.
package vrot_pkg;

  typedef enum logic [2:0] {
    ROTL = 3'd0,
    ROTR = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    SRA  = 3'd4
  } vrot_op_e;

  function automatic int amt_width(input int ew);
    return $clog2(ew);
  endfunction

  localparam int DEFAULT_EW    = 32;
  localparam int DEFAULT_AMT_W = amt_width(DEFAULT_EW);

endpackage

// File: rtl/vrot_lane.sv
// One element of the rotate/shift datapath; purely combinational.
module vrot_lane
  import vrot_pkg::*;
#(
  parameter int EW = 32,
  parameter int AW = amt_width(EW)
) (
  input  logic [EW-1:0] x,
  input  logic [AW-1:0] a,
  input  logic [2:0]    op,
  input  logic          en,
  output logic [EW-1:0] y
);

  logic [2*EW-1:0] lsh;
  logic [2*EW-1:0] rsh;

  // Shifting the doubled word gives rotate in one half and plain shift in
  // the other, so no shift-by-(EW-a) term is needed and a = 0 falls out as x.
  always_comb begin
    lsh = {x, x} << a;
    rsh = {x, x} >> a;
    y   = x;
    if (en) begin
      case (op)
        ROTL:    y = lsh[2*EW-1:EW];
        ROTR:    y = rsh[EW-1:0];
        SHL:     y = lsh[EW-1:0];
        SHR:     y = rsh[2*EW-1:EW];
        SRA:     y = $unsigned($signed(x) >>> a);
        default: y = x;
      endcase
    end
  end

endmodule

// File: rtl/vrot_pipe.sv
// Pipelined vector rotate/shift unit: lane datapath ahead of stage 1,
// optional plain register stage 2, valid/ready handshake on both sides.
module vrot_pipe
  import vrot_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int EW     = 32,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic                in_scalar,
  input  logic [LANES-1:0]    in_mask,
  input  logic [LANES*EW-1:0] in_data,
  input  logic [LANES*EW-1:0] in_amt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*EW-1:0] out_data
);

  localparam int AW = amt_width(EW);
  localparam int W  = LANES * EW;

  logic [W-1:0] lane_y;
  logic         unused_amt_bits;

  // Only the low AW bits of each amount field matter.
  assign unused_amt_bits = ^in_amt;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [AW-1:0] amt;
    assign amt = in_scalar ? in_amt[AW-1:0] : in_amt[i*EW +: AW];

    vrot_lane #(.EW(EW), .AW(AW)) u_lane (
      .x  (in_data[i*EW +: EW]),
      .a  (amt),
      .op (in_op),
      .en (in_mask[i]),
      .y  (lane_y[i*EW +: EW])
    );
  end

  logic         s1_load;
  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_data_q, s1_data_d;

  assign in_ready = s1_load && !rst;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) s1_data_d = lane_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (STAGES == 2) begin : g_two
    logic         s2_load;
    logic         s2_valid_q, s2_valid_d;
    logic [W-1:0] s2_data_q, s2_data_d;

    // A stage accepts when empty or when the stage after it moves.
    assign s2_load = !s2_valid_q || out_ready;
    assign s1_load = !s1_valid_q || s2_load;

    always_comb begin
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      if (s2_load) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) s2_data_d = s1_data_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
  end else begin : g_one
    assign s1_load   = !s1_valid_q || out_ready;
    assign out_valid = s1_valid_q;
    assign out_data  = s1_data_q;
  end

endmodule

// File: tb/tb_vrot_pipe.sv
// Self-checking bench for vrot_pipe: directed vectors with literal
// expectations plus a queue-based model checked on every output transfer.
module tb_vrot_pipe;

  localparam int LANES  = 4;
  localparam int EW     = 32;
  localparam int STAGES = 2;
  localparam int W      = LANES * EW;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic             in_scalar;
  logic [LANES-1:0] in_mask;
  logic [W-1:0]     in_data;
  logic [W-1:0]     in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;

  int           checks = 0;
  int           failures = 0;
  int           out_count = 0;
  logic [W-1:0] exp_q[$];
  logic         stalled_prev = 1'b0;
  logic [W-1:0] stalled_data = '0;

  vrot_pipe #(.LANES(LANES), .EW(EW), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_scalar (in_scalar),
    .in_mask   (in_mask),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Reference behaviour of one element, written from the operation definitions.
  function automatic logic [EW-1:0] lane_model(input logic [2:0] op, input logic [EW-1:0] x,
                                               input int a);
    logic [EW-1:0] r;
    if (a == 0) return x;
    case (op)
      3'd0:    r = (x << a) | (x >> (EW - a));
      3'd1:    r = (x >> a) | (x << (EW - a));
      3'd2:    r = x << a;
      3'd3:    r = x >> a;
      3'd4:    r = x[EW-1] ? ~((~x) >> a) : (x >> a);
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] vec_model(input logic [2:0] op, input logic scalar,
                                             input logic [LANES-1:0] mask,
                                             input logic [W-1:0] data, input logic [W-1:0] amt);
    logic [W-1:0]  r;
    logic [EW-1:0] field;
    for (int i = 0; i < LANES; i++) begin
      field = scalar ? amt[EW-1:0] : amt[i*EW +: EW];
      if (mask[i]) r[i*EW +: EW] = lane_model(op, data[i*EW +: EW], int'(field % EW));
      else         r[i*EW +: EW] = data[i*EW +: EW];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: record accepted beats, compare every output transfer, watch stalls.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        check("stall_valid_hold", W'(out_valid), W'(1));
        check("stall_data_hold", out_data, stalled_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL spurious_output: got %h expected no beat", out_data);
        end else begin
          check("model_compare", out_data, exp_q.pop_front());
          out_count++;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(vec_model(in_op, in_scalar, in_mask, in_data, in_amt));
      stalled_prev = out_valid && !out_ready;
      stalled_data = out_data;
    end
  end

  // Drive one beat and hold it until accepted; returns just after the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic scalar,
                               input logic [LANES-1:0] mask, input logic [W-1:0] data,
                               input logic [W-1:0] amt);
    logic accepted;
    accepted  = 1'b0;
    in_op     = op;
    in_scalar = scalar;
    in_mask   = mask;
    in_data   = data;
    in_amt    = amt;
    in_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for the next output and compare against a literal; exp_lat = 0 skips latency check.
  task automatic checkOutput(input string name, input logic [W-1:0] exp, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check(name, out_data, exp);
    if (exp_lat > 0) check({name, "_latency"}, W'(lat), W'(exp_lat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int acc_at_stall;
    logic ir_at_stall;
    int count_before;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_scalar = 1'b0;
    in_mask   = '1;
    in_data   = '0;
    in_amt    = '0;
    out_ready = 1'b1;

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", W'(in_ready), W'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", W'(out_valid), W'(0));
    check("reset_in_ready", W'(in_ready), W'(1));
    check("reset_out_data", out_data, '0);
    @(posedge clk);
    #1;

    // Directed vectors with literal results
    applyStimulus(3'd0, 1'b0, 4'hF, {4{32'h80000001}}, {32'd8, 32'd31, 32'd1, 32'd0});
    checkOutput("rotl_per_lane", {32'h00000180, 32'hC0000000, 32'h00000003, 32'h80000001}, 2);

    applyStimulus(3'd1, 1'b1, 4'hF, {4{32'h12345678}}, {32'h1F, 32'h1F, 32'h1F, 32'd4});
    checkOutput("rotr_scalar", {4{32'h81234567}}, 2);

    applyStimulus(3'd4, 1'b0, 4'hF, {4{32'hF0000000}}, {4{32'd4}});
    checkOutput("sra_neg", {4{32'hFF000000}}, 0);

    applyStimulus(3'd3, 1'b0, 4'hF, {4{32'hF0000000}}, {4{32'd4}});
    checkOutput("shr", {4{32'h0F000000}}, 0);

    applyStimulus(3'd3, 1'b0, 4'hF, {4{32'hF0000000}}, {4{32'h24}});
    checkOutput("shr_amt_wrap", {4{32'h0F000000}}, 0);

    applyStimulus(3'd4, 1'b0, 4'hF, {4{32'h70000000}}, {4{32'h24}});
    checkOutput("sra_pos", {4{32'h07000000}}, 0);

    applyStimulus(3'd2, 1'b0, 4'hF, {4{32'h12345678}}, {4{32'd4}});
    checkOutput("shl", {4{32'h23456780}}, 0);

    applyStimulus(3'd7, 1'b0, 4'hF, {4{32'h12345678}}, {4{32'd4}});
    checkOutput("reserved_op", {4{32'h12345678}}, 0);

    applyStimulus(3'd1, 1'b0, 4'hF, {4{32'hDEADBEEF}}, {4{32'h20}});
    checkOutput("rotr_amt_zero", {4{32'hDEADBEEF}}, 0);

    applyStimulus(3'd0, 1'b1, 4'b0101, {4{32'hAABBCCDD}}, {4{32'd8}});
    checkOutput("lane_mask", {32'hAABBCCDD, 32'hBBCCDDAA, 32'hAABBCCDD, 32'hBBCCDDAA}, 0);

    // Backpressure: stall output for 5 cycles while streaming 6 tagged beats
    count_before = out_count;
    out_ready    = 1'b0;
    acc          = 0;
    acc_at_stall = -1;
    ir_at_stall  = 1'b1;
    for (int cyc = 0; cyc < 60 && acc < 6; cyc++) begin
      if (cyc == 5) out_ready = 1'b1;
      in_valid  = 1'b1;
      in_op     = 3'd0;
      in_scalar = 1'b1;
      in_mask   = 4'hF;
      in_amt    = {4{32'd4}};
      for (int l = 0; l < LANES; l++) in_data[l*EW +: EW] = 32'((acc << 8) | l);
      @(negedge clk);
      if (in_ready) acc++;
      if (cyc == 4) begin
        acc_at_stall = acc;
        ir_at_stall  = in_ready;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_accepts_while_stalled", W'(acc_at_stall), W'(2));
    check("bp_in_ready_full", W'(ir_at_stall), W'(0));
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("bp_all_results", W'(out_count - count_before), W'(6));

    // Reset with two beats in flight
    out_ready = 1'b0;
    applyStimulus(3'd2, 1'b0, 4'hF, {4{32'h00000001}}, {4{32'd1}});
    applyStimulus(3'd2, 1'b0, 4'hF, {4{32'h00000002}}, {4{32'd1}});
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = {4{32'h55555555}};
    @(negedge clk);
    check("rst_blocks_input", W'(in_ready), W'(0));
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_flush_valid", W'(out_valid), W'(0));
    check("rst_flush_in_ready", W'(in_ready), W'(1));
    check("rst_flush_data", out_data, '0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(3'd0, 1'b0, 4'hF, {4{32'h00000001}}, {32'd3, 32'd2, 32'd1, 32'd0});
    checkOutput("post_rst_beat", {32'h00000008, 32'h00000004, 32'h00000002, 32'h00000001}, 2);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
